// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encodings shared by the sequential ALU
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational result/carry/overflow for single-cycle ops
module alu_comb_core import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             overflow_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_v;
    logic           sub_v;
    logic           slt;
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    // sign xor overflow keeps the signed compare right when a-b overflows
    assign slt   = diff[WIDTH-1] ^ sub_v;
    // select per-op result; reserved and MUL codes yield zero here
    always_comb begin
        res_o      = op_i == OP_AND ? a_i & b_i :
                     op_i == OP_OR  ? a_i | b_i :
                     op_i == OP_NOR ? ~(a_i | b_i) :
                     op_i == OP_ADD ? sum[WIDTH-1:0] :
                     op_i == OP_SUB ? diff[WIDTH-1:0] :
                     op_i == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} : '0;
        carry_o    = op_i == OP_ADD ? sum[WIDTH] :
                     (op_i == OP_SUB || op_i == OP_SLT) ? diff[WIDTH] : 1'b0;
        overflow_o = op_i == OP_ADD ? add_v : op_i == OP_SUB ? sub_v : 1'b0;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and shift-and-add multiplier
module seq_alu import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       signal,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               vld_q, vld_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   core_res;
    logic               core_c;
    logic               core_v;
    logic               accept;
    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a_i        (a),
        .b_i        (b),
        .op_i       (signal),
        .res_o      (core_res),
        .carry_o    (core_c),
        .overflow_o (core_v)
    );
    assign in_ready  = !rst && state_q == ST_IDLE && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = vld_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    // next-state: accept/retire in IDLE, iterate MUL, wait for consumer in HOLD
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        vld_d    = vld_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && signal == OP_MUL) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    vld_d    = 1'b0;
                    state_d  = ST_MUL;
                end else if (accept) begin
                    out_d   = core_res;
                    zero_d  = core_res == '0;
                    carry_d = core_c;
                    ovf_d   = core_v;
                    vld_d   = 1'b1;
                end else if (out_ready) begin
                    vld_d = 1'b0;
                end
            end
            ST_MUL: begin
                if (cnt_q == CW'(WIDTH)) begin
                    out_d   = acc_q[WIDTH-1:0];
                    zero_d  = acc_q[WIDTH-1:0] == '0;
                    carry_d = 1'b0;
                    ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    acc_d    = mplier_q[0] ? acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : acc_q;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // state and datapath registers; reset aborts any multiply and drops results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            vld_q    <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] signal = 3'b000;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       zero;
    logic       carry;
    logic       overflow;
    int         total = 0;
    int         bad = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signal    (signal),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one op, wait (bounded) for in_ready, then let the accept edge pass
    task automatic issue(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
        int n;
        signal   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({out, out_valid, zero, carry, overflow} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: out=%h v=%b z=%b c=%b o=%b want all 0", out, out_valid, zero, carry, overflow);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        issue(3'b010, 8'h7F, 8'h01);
        total++;
        if ({out, out_valid, zero, carry, overflow} !== {8'h80, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf: out=%h v=%b z=%b c=%b o=%b want 80 1 0 0 1", out, out_valid, zero, carry, overflow);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_ovf_one_cycle: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_sub_equal();
        issue(3'b110, 8'h05, 8'h05);
        total++;
        if ({out, out_valid, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_eq: out=%h v=%b z=%b c=%b o=%b want 00 1 1 1 0", out, out_valid, zero, carry, overflow);
        end
    endtask

    task automatic test_slt();
        issue(3'b111, 8'h80, 8'h7F);
        total++;
        if ({out, zero, overflow} !== {8'h01, 1'b0, 1'b0}) begin bad++; $display("FAIL slt_80_7f: out=%h z=%b o=%b want 01 0 0", out, zero, overflow); end
        issue(3'b111, 8'h7F, 8'h80);
        total++;
        if ({out, zero} !== {8'h00, 1'b1}) begin bad++; $display("FAIL slt_7f_80: out=%h z=%b want 00 1", out, zero); end
        issue(3'b111, 8'hFF, 8'h01);
        total++;
        if ({out, carry} !== {8'h01, 1'b1}) begin bad++; $display("FAIL slt_ff_01: out=%h c=%b want 01 1", out, carry); end
    endtask

    // ops presented every cycle with out_ready high: one result per cycle
    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        signal = 3'b000; a = 8'hF0; b = 8'h3C;
        step();
        total++;
        if ({out, out_valid, zero} !== {8'h30, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_and: out=%h v=%b z=%b want 30 1 0", out, out_valid, zero); end
        signal = 3'b100; a = 8'h0F; b = 8'hF0;
        step();
        total++;
        if ({out, out_valid, zero} !== {8'h00, 1'b1, 1'b1}) begin bad++; $display("FAIL b2b_nor: out=%h v=%b z=%b want 00 1 1", out, out_valid, zero); end
        signal = 3'b010; a = 8'hFF; b = 8'h01;
        step();
        total++;
        if ({out, out_valid, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_add_carry: out=%h v=%b z=%b c=%b o=%b want 00 1 1 1 0", out, out_valid, zero, carry, overflow);
        end
        signal = 3'b101; a = 8'hAA; b = 8'h55;
        step();
        total++;
        if ({out, out_valid, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_reserved: out=%h v=%b z=%b c=%b o=%b want 00 1 1 0 0", out, out_valid, zero, carry, overflow);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_mul();
        int n;
        logic busy_ok;
        out_ready = 1'b1;
        issue(3'b011, 8'h0F, 8'h11);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 20) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            n++;
        end
        total++;
        if (n != 9) begin bad++; $display("FAIL mul_latency: got %0d cycles want 9", n); end
        total++;
        if (busy_ok !== 1'b1) begin bad++; $display("FAIL mul_busy_ready: in_ready seen high while multiplying, want 0"); end
        total++;
        if ({out, zero, carry, overflow} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mul_0f_11: out=%h z=%b c=%b o=%b want ff 0 0 0", out, zero, carry, overflow);
        end
        issue(3'b011, 8'h10, 8'h10);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        total++;
        if ({out, out_valid, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL mul_10_10: out=%h v=%b z=%b c=%b o=%b want 00 1 1 0 1", out, out_valid, zero, carry, overflow);
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic held_ok;
        out_ready = 1'b0;
        issue(3'b010, 8'h03, 8'h04);
        in_valid = 1'b1;
        signal = 3'b001; a = 8'hF0; b = 8'h0F;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out !== 8'h07 || out_valid !== 1'b1 || in_ready !== 1'b0) held_ok = 1'b0;
            step();
        end
        total++;
        if (held_ok !== 1'b1) begin bad++; $display("FAIL bp_hold: out=%h v=%b rdy=%b want 07 1 0 throughout", out, out_valid, in_ready); end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++;
        if ({out, out_valid} !== {8'hFF, 1'b1}) begin bad++; $display("FAIL bp_or: out=%h v=%b want ff 1", out, out_valid); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic leak;
        out_ready = 1'b1;
        issue(3'b011, 8'hFF, 8'hFF);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({out, out_valid, in_ready} !== {8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid_mul: out=%h v=%b rdy=%b want 00 0 1", out, out_valid, in_ready);
        end
        leak = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) leak = 1'b1;
            step();
        end
        total++;
        if (leak !== 1'b0) begin bad++; $display("FAIL rst_mid_mul_leak: out_valid=1 seen after reset, want never"); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_slt();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised-width ALU with a valid/ready handshake on input and output, and a registered result.
- Single-cycle ops: AND/OR/NOR/ADD/SUB/SLT.
- Multi-cycle op: unsigned shift-and-add multiply.
- Outputs zero/carry/overflow flags.
- Sits between the operand-fetch stage and writeback. Supersedes the fixed 4-bit combinational ALU slice chain.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are presented this cycle.
- in_ready  out  1  block will accept the op this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signal  in  3  op select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MUL, 101 reserved.
- out  out  WIDTH  result.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- zero  out  1  out == 0.
- carry  out  1  ADD: carry-out; SUB/SLT: carry-out of a + ~b + 1, so 1 means no borrow; else 0.
- overflow  out  1  ADD/SUB: signed overflow; MUL: product high half nonzero; else 0.

Behaviour:
- Reset: state=IDLE; out=0; zero=0, carry=0, overflow=0; out_valid=0; multiplier registers cleared. in_ready is 0 during the rst cycle.
- Accept condition: in_valid && in_ready at a rising edge. a, b and signal are captured only on accept.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A result taken and a new op accepted in the same cycle is legal and gives back-to-back throughput of 1 op/cycle.
- States: IDLE, MUL, HOLD.
  - IDLE: on accept of a non-MUL op, out/flags are registered. out_valid=1 the next cycle (latency 1), state stays IDLE.
  - IDLE: on accept of MUL, load multiplicand=a, multiplier=b, accumulator=0 (2*WIDTH bits), count=0, go to MUL.
  - MUL: each cycle, if multiplier[0] then accumulator += multiplicand << count. Shift the multiplier right; count++.
  - MUL exit: after WIDTH iterations, out=accumulator[WIDTH-1:0] and overflow=|accumulator[2W-1:W], carry=0. out_valid=1, go to HOLD.
  - MUL latency: out_valid asserts exactly WIDTH+1 cycles after the accept edge.
  - HOLD: wait for out_ready, then go to IDLE.
- Output holding: out/flags/out_valid hold stable while out_valid && !out_ready. out_valid clears on the handshake unless a new single-cycle op is accepted in the same cycle.
- Arithmetic:
  - SUB uses a + ~b + 1.
  - SLT out = {WIDTH-1 zeros, sign(a-b) XOR overflow(a-b)}, giving a correct signed compare even when overflow occurs.
  - NOR out = ~(a|b).
  - Reserved op 101: out=0, zero=1, carry=0, overflow=0, latency 1.
- zero is computed from the final out value for every op, including MUL and SLT.
- Reset mid-operation: rst has priority over everything. It aborts MUL immediately; no partial result is emitted. Any pending out_valid is dropped.
- Inputs while busy: a/b/signal changes while in_ready=0 are ignored.

Decomposition:
- Package alu_pkg:
  - op localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL.
  - state encodings: ST_IDLE, ST_MUL, ST_HOLD.
- Sub-module alu_comb_core: purely combinational, parametrised WIDTH. Computes result, carry and overflow for the single-cycle ops. The top contains the FSM, the multiplier datapath and the output registers.

Test Plan:
- Signed overflow on ADD: WIDTH=8, ADD a=8'h7F, b=8'h01, out_ready=1 -> next cycle out=8'h80, overflow=1, carry=0, zero=0, out_valid for 1 cycle.
- Equal operands on SUB: SUB a=8'h05, b=8'h05 -> out=8'h00, zero=1, carry=1, overflow=0.
- Signed compare incl. overflow case: SLT a=8'h80, b=8'h7F -> out=8'h01. SLT a=8'h7F, b=8'h80 -> out=8'h00. SLT a=8'hFF, b=8'h01 -> out=8'h01.
- MUL latency and overflow: MUL a=8'h0F, b=8'h11 -> out=8'hFF, overflow=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout. MUL a=8'h10, b=8'h10 -> out=8'h00, zero=1, overflow=1.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> out=8'h07 held stable, in_ready=0, a second in_valid not accepted. Raise out_ready -> same cycle in_ready=1; a new OR 8'hF0|8'h0F appears as 8'hFF next cycle.
- Reset mid-MUL: assert rst on the 3rd MUL cycle -> following cycle state=IDLE, out=0, out_valid=0, in_ready=1. No MUL result is ever presented.
